// File: rtl/fu_issue_scheduler.sv
// In-order single-issue scheduler feeding four functional units, with a
// scalar/matrix register scoreboard and a halt sequence that drains every FU.
module fu_issue_scheduler #(
  parameter int PW = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            d_valid,
  output logic            d_ready,
  input  logic [1:0]      d_fu,
  input  logic            d_halt,
  input  logic            d_s_we,
  input  logic [4:0]      d_s_rd,
  input  logic [4:0]      d_s_rs1,
  input  logic [4:0]      d_s_rs2,
  input  logic [1:0]      d_s_use,
  input  logic            d_m_we,
  input  logic [3:0]      d_m_rd,
  input  logic [3:0]      d_m_rs1,
  input  logic [3:0]      d_m_rs2,
  input  logic [3:0]      d_m_rs3,
  input  logic [2:0]      d_m_use,
  input  logic [PW-1:0]   d_payload,
  output logic [3:0]      iss_valid,
  input  logic [3:0]      iss_ready,
  output logic [4*PW-1:0] iss_payload,
  input  logic [3:0]      wb_valid,
  output logic [3:0]      fu_busy,
  output logic            halted,
  output logic [1:0]      dbg_state
);

  // Handshakes: the decode side transfers when d_valid && d_ready (d_ready is
  // only ever high together with d_valid); FU f transfers on an edge with
  // iss_valid[f] && iss_ready[f]; iss_valid/iss_payload hold until then.

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      busy_q, pend_q;
  logic [31:0]     s_busy_q;
  logic [15:0]     m_busy_q;
  logic            dst_s_we_q [4];
  logic [4:0]      dst_s_rd_q [4];
  logic            dst_m_we_q [4];
  logic [3:0]      dst_m_rd_q [4];
  logic [PW-1:0]   pl_q [4];

  logic            raw, waw, nonhalt_ok, accept;
  logic [3:0]      acc_fu, wb_ok, hs;
  logic [31:0]     s_clr, s_set;
  logic [15:0]     m_clr, m_set;

  assign raw = (d_s_use[0] && s_busy_q[d_s_rs1]) ||
               (d_s_use[1] && s_busy_q[d_s_rs2]) ||
               (d_m_use[0] && m_busy_q[d_m_rs1]) ||
               (d_m_use[1] && m_busy_q[d_m_rs2]) ||
               (d_m_use[2] && m_busy_q[d_m_rs3]);
  assign waw = (d_s_we && s_busy_q[d_s_rd]) || (d_m_we && m_busy_q[d_m_rd]);
  assign nonhalt_ok = !busy_q[d_fu] && !raw && !waw;

  // Halt is taken regardless of hazards; the drain happens afterwards.
  assign d_ready = !RST && (state_q == RUN) && d_valid && (d_halt || nonhalt_ok);
  assign accept  = d_ready && !d_halt;
  assign acc_fu  = accept ? (4'b0001 << d_fu) : 4'b0000;

  // Completions count only once the FU has actually taken the instruction.
  assign wb_ok = wb_valid & busy_q & ~pend_q;
  assign hs    = pend_q & iss_ready;

  always_comb begin
    s_clr = '0;
    m_clr = '0;
    for (int f = 0; f < 4; f++) begin
      if (wb_ok[f]) begin
        if (dst_s_we_q[f]) s_clr[dst_s_rd_q[f]] = 1'b1;
        if (dst_m_we_q[f]) m_clr[dst_m_rd_q[f]] = 1'b1;
      end
    end
  end

  assign s_set = (accept && d_s_we) ? (32'd1 << d_s_rd) : 32'd0;
  assign m_set = (accept && d_m_we) ? (16'd1 << d_m_rd) : 16'd0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (d_ready && d_halt) state_d = DRAIN;
      DRAIN:   if ((busy_q & ~wb_ok) == 4'd0) state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RUN;
      busy_q   <= '0;
      pend_q   <= '0;
      s_busy_q <= '0;
      m_busy_q <= '0;
      for (int f = 0; f < 4; f++) begin
        dst_s_we_q[f] <= 1'b0;
        dst_s_rd_q[f] <= '0;
        dst_m_we_q[f] <= 1'b0;
        dst_m_rd_q[f] <= '0;
        pl_q[f]       <= '0;
      end
    end else begin
      state_q  <= state_d;
      busy_q   <= (busy_q & ~wb_ok) | acc_fu;
      pend_q   <= (pend_q & ~hs) | acc_fu;
      // x0 is never tracked, so its bit is forced clear every cycle.
      s_busy_q <= ((s_busy_q & ~s_clr) | s_set) & ~32'd1;
      m_busy_q <= (m_busy_q & ~m_clr) | m_set;
      for (int f = 0; f < 4; f++) begin
        if (acc_fu[f]) begin
          dst_s_we_q[f] <= d_s_we;
          dst_s_rd_q[f] <= d_s_rd;
          dst_m_we_q[f] <= d_m_we;
          dst_m_rd_q[f] <= d_m_rd;
          pl_q[f]       <= d_payload;
        end
      end
    end
  end

  always_comb begin
    for (int f = 0; f < 4; f++) iss_payload[f*PW +: PW] = pl_q[f];
  end

  assign iss_valid = pend_q;
  assign fu_busy   = busy_q;
  assign halted    = (state_q == HALTED);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Self-checking bench for fu_issue_scheduler: directed scenarios plus random
// traffic, all compared every cycle against an ownership-based reference model.
module tb_fu_issue_scheduler;
  localparam int PW = 64;
  localparam int W  = 4 * PW;

  logic            CLK = 1'b0;
  logic            RST;
  logic            d_valid, d_ready, d_halt, d_s_we, d_m_we;
  logic [1:0]      d_fu, d_s_use, dbg_state;
  logic [4:0]      d_s_rd, d_s_rs1, d_s_rs2;
  logic [3:0]      d_m_rd, d_m_rs1, d_m_rs2, d_m_rs3;
  logic [2:0]      d_m_use;
  logic [PW-1:0]   d_payload;
  logic [3:0]      iss_valid, iss_ready, wb_valid, fu_busy;
  logic [W-1:0]    iss_payload;
  logic            halted;

  fu_issue_scheduler #(.PW(PW)) dut (
    .CLK(CLK), .RST(RST), .d_valid(d_valid), .d_ready(d_ready), .d_fu(d_fu),
    .d_halt(d_halt), .d_s_we(d_s_we), .d_s_rd(d_s_rd), .d_s_rs1(d_s_rs1),
    .d_s_rs2(d_s_rs2), .d_s_use(d_s_use), .d_m_we(d_m_we), .d_m_rd(d_m_rd),
    .d_m_rs1(d_m_rs1), .d_m_rs2(d_m_rs2), .d_m_rs3(d_m_rs3), .d_m_use(d_m_use),
    .d_payload(d_payload), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_payload(iss_payload), .wb_valid(wb_valid), .fu_busy(fu_busy),
    .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Each FU is idle (0), waiting to be issued (1) or executing (2).
  // Each register remembers which FU will write it (-1: nobody).
  int            fu_st [4];
  logic [PW-1:0] fu_pl [4];
  int            s_own [32];
  int            m_own [16];
  int            phase;          // 0 run, 1 drain, 2 halted
  logic [PW+1:0] exp_q [$];      // {fu, payload} awaiting an issue handshake

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 4; f++) begin
      fu_st[f] = 0;
      fu_pl[f] = '0;
    end
    for (int r = 0; r < 32; r++) s_own[r] = -1;
    for (int r = 0; r < 16; r++) m_own[r] = -1;
    phase = 0;
    exp_q.delete();
  endtask

  function automatic bit model_ready();
    bit hz;
    if (phase != 0 || !d_valid) return 0;
    if (d_halt) return 1;
    if (fu_st[d_fu] != 0) return 0;
    hz = 0;
    if (d_s_use[0] && d_s_rs1 != 0 && s_own[d_s_rs1] != -1) hz = 1;
    if (d_s_use[1] && d_s_rs2 != 0 && s_own[d_s_rs2] != -1) hz = 1;
    if (d_m_use[0] && m_own[d_m_rs1] != -1) hz = 1;
    if (d_m_use[1] && m_own[d_m_rs2] != -1) hz = 1;
    if (d_m_use[2] && m_own[d_m_rs3] != -1) hz = 1;
    if (d_s_we && d_s_rd != 0 && s_own[d_s_rd] != -1) hz = 1;
    if (d_m_we && m_own[d_m_rd] != -1) hz = 1;
    return !hz;
  endfunction

  // Compare all outputs, track issue handshakes, then advance the model by one edge.
  task automatic check_and_step();
    bit            rdy, found, all_idle;
    logic [3:0]    e_iv, e_busy;
    logic [W-1:0]  e_pl;
    int            idx;
    rdy = model_ready();
    for (int f = 0; f < 4; f++) begin
      e_iv[f]   = (fu_st[f] == 1);
      e_busy[f] = (fu_st[f] != 0);
      e_pl[f*PW +: PW] = fu_pl[f];
    end
    check("d_ready", d_ready, rdy);
    check("iss_valid", iss_valid, e_iv);
    check("fu_busy", fu_busy, e_busy);
    check("halted", halted, phase == 2);
    check("dbg_state", dbg_state, phase);
    check("iss_payload", iss_payload, e_pl);

    for (int f = 0; f < 4; f++) begin
      if (iss_valid[f] && iss_ready[f]) begin
        found = 0;
        idx = 0;
        for (int i = 0; i < exp_q.size(); i++)
          if (!found && exp_q[i][PW+1:PW] == f[1:0]) begin found = 1; idx = i; end
        check("hs_found", found, 1);
        if (found) begin
          check("hs_payload", iss_payload[f*PW +: PW], exp_q[idx][PW-1:0]);
          exp_q.delete(idx);
        end
      end
    end

    // completions, then issues, then the new accept
    for (int f = 0; f < 4; f++) begin
      if (wb_valid[f] && fu_st[f] == 2) begin
        fu_st[f] = 0;
        for (int r = 0; r < 32; r++) if (s_own[r] == f) s_own[r] = -1;
        for (int r = 0; r < 16; r++) if (m_own[r] == f) m_own[r] = -1;
      end else if (fu_st[f] == 1 && iss_ready[f]) begin
        fu_st[f] = 2;
      end
    end
    if (rdy && d_halt) begin
      phase = 1;
    end else if (rdy) begin
      fu_st[d_fu] = 1;
      fu_pl[d_fu] = d_payload;
      if (d_s_we && d_s_rd != 0) s_own[d_s_rd] = d_fu;
      if (d_m_we) m_own[d_m_rd] = d_fu;
      exp_q.push_back({d_fu, d_payload});
    end else if (phase == 1) begin
      all_idle = 1;
      for (int f = 0; f < 4; f++) if (fu_st[f] != 0) all_idle = 0;
      if (all_idle) begin
        phase = 2;
        check("drain_q_empty", exp_q.size(), 0);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at posedge+1; outputs are sampled at posedge+3.
  task automatic cycle();
    #2;
    check_and_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [1:0] fu, input logic halt, input logic s_we,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [1:0] s_use,
                     input logic m_we, input logic [3:0] mrd, input logic [3:0] mrs1,
                     input logic [2:0] m_use);
    d_valid = 1; d_fu = fu; d_halt = halt;
    d_s_we = s_we; d_s_rd = rd; d_s_rs1 = rs1; d_s_rs2 = 5'd0; d_s_use = s_use;
    d_m_we = m_we; d_m_rd = mrd; d_m_rs1 = mrs1; d_m_rs2 = 4'd0; d_m_rs3 = 4'd0;
    d_m_use = m_use;
    d_payload = {$urandom, $urandom};
  endtask

  task automatic put_rand();
    d_valid = ($urandom_range(0, 3) != 0);
    d_fu = 2'($urandom_range(0, 3));
    d_halt = ($urandom_range(0, 79) == 0);
    d_s_we = 1'($urandom);
    d_s_rd = 5'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7));
    d_s_rs1 = 5'($urandom_range(0, 7));
    d_s_rs2 = 5'($urandom_range(0, 7));
    d_s_use = 2'($urandom);
    d_m_we = 1'($urandom);
    d_m_rd = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 3));
    d_m_rs1 = 4'($urandom_range(0, 3));
    d_m_rs2 = 4'($urandom_range(0, 3));
    d_m_rs3 = 4'($urandom_range(0, 3));
    d_m_use = 3'($urandom);
    d_payload = {$urandom, $urandom};
    iss_ready = 4'($urandom);
    wb_valid = 4'($urandom) & 4'($urandom);
  endtask

  task automatic idle();
    d_valid = 0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    d_valid = 1;
    RST = 1;
    #1;
    check("rst_iss_valid", iss_valid, 4'd0);
    check("rst_fu_busy", fu_busy, 4'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_d_ready", d_ready, 1'b0);
    check("rst_payload", iss_payload, '0);
    model_reset();
    @(posedge CLK);
    #1;
    check("rst_hold_d_ready", d_ready, 1'b0);
    RST = 0;
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1; d_valid = 0; d_halt = 0; d_fu = 0; d_s_we = 0; d_s_rd = 0;
    d_s_rs1 = 0; d_s_rs2 = 0; d_s_use = 0; d_m_we = 0; d_m_rd = 0; d_m_rs1 = 0;
    d_m_rs2 = 0; d_m_rs3 = 0; d_m_use = 0; d_payload = 0;
    iss_ready = 4'b1111; wb_valid = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // RAW on matrix: store reading m3 waits for GEMM completion
    put(2'd3, 0, 0, 0, 0, 2'b00, 1, 4'd3, 4'd0, 3'b000); cycle();
    put(2'd2, 0, 0, 0, 0, 2'b00, 0, 4'd0, 4'd3, 3'b001);
    repeat (4) cycle();
    wb_valid = 4'b1000; cycle(); wb_valid = 0;
    cycle(); idle(); repeat (2) cycle();
    wb_valid = 4'b0100; cycle(); wb_valid = 0;

    // independent back-to-back accepts with FUs not ready
    iss_ready = 4'b0000;
    put(2'd0, 0, 1, 5'd5, 0, 2'b00, 0, 0, 0, 3'b000); cycle();
    put(2'd1, 0, 1, 5'd6, 5'd7, 2'b01, 0, 0, 0, 3'b000); cycle();
    idle(); cycle();
    wb_valid = 4'b0011; cycle(); wb_valid = 0;  // ignored: still pending
    iss_ready = 4'b1111; cycle();
    wb_valid = 4'b0011; cycle(); wb_valid = 0;

    // structural hazard on GEMM, then x0 writer/reader never stall
    put(2'd3, 0, 0, 0, 0, 2'b00, 1, 4'd1, 4'd0, 3'b000); cycle();
    put(2'd3, 0, 0, 0, 0, 2'b00, 1, 4'd2, 4'd4, 3'b001);
    repeat (3) cycle();
    wb_valid = 4'b1000; cycle(); wb_valid = 0;
    cycle();
    put(2'd0, 0, 1, 5'd0, 0, 2'b00, 0, 0, 0, 3'b000); cycle();
    put(2'd1, 0, 1, 5'd0, 5'd0, 2'b01, 0, 0, 0, 3'b000); cycle();
    idle(); cycle();
    wb_valid = 4'b1011; cycle(); wb_valid = 0;

    // WAW on x9 plus two simultaneous completions
    put(2'd0, 0, 1, 5'd10, 0, 2'b00, 0, 0, 0, 3'b000); cycle();
    put(2'd1, 0, 1, 5'd9, 0, 2'b00, 0, 0, 0, 3'b000); cycle();
    put(2'd0, 0, 1, 5'd9, 0, 2'b00, 0, 0, 0, 3'b000);
    repeat (2) cycle();
    wb_valid = 4'b0011; cycle(); wb_valid = 0;
    cycle(); idle(); cycle();
    wb_valid = 4'b0001; cycle(); wb_valid = 0;

    // halt drains an in-flight GEMM, then stays halted
    put(2'd3, 0, 0, 0, 0, 2'b00, 1, 4'd5, 4'd0, 3'b000); cycle();
    put(2'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000); cycle();
    put(2'd0, 0, 1, 5'd1, 0, 2'b00, 0, 0, 0, 3'b000);
    repeat (2) cycle();
    wb_valid = 4'b1000; cycle(); wb_valid = 0;
    repeat (3) cycle();
    check("halt_reached", halted, 1'b1);

    // reset mid-stream with a GEMM pending
    idle(); do_reset();
    iss_ready = 4'b0000;
    put(2'd3, 0, 0, 0, 0, 2'b00, 1, 4'd7, 4'd0, 3'b000); cycle();
    idle(); cycle();
    do_reset();
    iss_ready = 4'b1111;
    put(2'd0, 0, 1, 5'd3, 0, 2'b00, 0, 0, 0, 3'b000); cycle();
    idle(); wb_valid = 4'b1000; cycle(); wb_valid = 0;
    cycle(); wb_valid = 4'b0001; cycle(); wb_valid = 0;

    // random traffic with occasional halts and resets
    for (int n = 0; n < 4000; n++) begin
      if (phase == 2 && $urandom_range(0, 3) == 0) do_reset();
      else if ($urandom_range(0, 599) == 0) do_reset();
      put_rand();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
